a_sum_ser: RTL and testbench

- Parametrised multi-cycle adder; generalises the single-bit full-adder cell to a WIDTH-bit operand sum.
- Processes STEP bits per clock through a ripple chain of full adders, with a registered carry between steps.
- Uses a 4-phase req/ack handshake, so it drops into the async-style datapath as a clocked arithmetic element between operand registers and the result bus.

---
 rtl/a_sum_pkg.sv | 20 ++
 rtl/a_sum_ser_if.sv | 23 ++
 rtl/a_sum_step.sv | 21 ++
 rtl/a_sum_ser.sv | 138 +++++++++++++
 tb/tb_a_sum_ser.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/a_sum_pkg.sv
// Shared definitions for the serial multi-cycle adder a_sum_ser:
// FSM state type, NULL spacer constant and counter sizing helper.
package a_sum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } a_sum_state_e;

    // Spacer value driven on the result bus when no valid data is present
    // (only used when A_SUM_NULL_EN is defined).
    localparam logic NULL_BIT = 1'bz;

    // Width of a counter that must hold values 0 .. n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/a_sum_ser_if.sv
// Operand / result handshake bundle for a_sum_ser (4-phase req/ack).
interface a_sum_ser_if #(
    parameter int WIDTH = 8
) ();
    logic             req;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             ack;
    logic             busy;
    logic [WIDTH-1:0] os;
    logic             oc;

    modport master (
        output req, a, b, ci,
        input  ack, busy, os, oc
    );

    modport slave (
        input  req, a, b, ci,
        output ack, busy, os, oc
    );
endinterface

// File: rtl/a_sum_step.sv
// Combinational STEP-bit ripple adder built from a chain of full-adder cells.
module a_sum_step #(
    parameter int STEP = 1
) (
    input  logic [STEP-1:0] a,
    input  logic [STEP-1:0] b,
    input  logic            ci,
    output logic [STEP-1:0] s,
    output logic            co
);
    logic [STEP:0] c_s;

    assign c_s[0] = ci;

    for (genvar i = 0; i < STEP; i++) begin : g_fa
        assign s[i]     = a[i] ^ b[i] ^ c_s[i];
        assign c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
    end

    assign co = c_s[STEP];
endmodule

// File: rtl/a_sum_ser.sv
// a_sum_ser: WIDTH-bit adder processing STEP bits per clock with a
// registered carry, behind a 4-phase req/ack handshake.
// Optional macro A_SUM_NULL_EN: os/oc drive the 'z NULL spacer whenever
// ack is low, and also at DONE when an operand bit was x/z at capture.
module a_sum_ser
    import a_sum_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic        clk,
    input  logic        rst,
    a_sum_ser_if.slave  bus
);
    localparam int N  = (STEP > 0) ? (WIDTH / STEP) : 1;
    localparam int CW = cnt_width(N);

    if ((WIDTH < 1) || (STEP < 1) || ((WIDTH % STEP) != 0)) begin : g_bad_cfg
        $fatal(1, "a_sum_ser: STEP must be >= 1 and divide WIDTH");
    end

    a_sum_state_e     state_r, state_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] a_r, b_r, sum_r, os_r;
    logic             c_r, oc_r, ack_r, busy_r;
    logic             capture_s, step_s, last_s;
    logic [STEP-1:0]  s_s;
    logic             co_s;
    logic [WIDTH-1:0] sum_nxt_s;

    // Operands are shifted right each step, so the active slice is always
    // the low STEP bits; this equals adding the slice at offset cnt*STEP.
    a_sum_step #(.STEP(STEP)) u_step (
        .a  (a_r[STEP-1:0]),
        .b  (b_r[STEP-1:0]),
        .ci (c_r),
        .s  (s_s),
        .co (co_s)
    );

    // New result slice enters at the top; after N steps it sits in place.
    assign sum_nxt_s = (sum_r >> STEP) | (WIDTH'(s_s) << (WIDTH - STEP));

    // Next-state and datapath control decode.
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        step_s      = 1'b0;
        last_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req) begin
                    capture_s   = 1'b1;
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (cnt_r == CW'(N - 1)) begin
                    last_s      = 1'b1;
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (!bus.req) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, handshake outputs and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            a_r     <= '0;
            b_r     <= '0;
            c_r     <= 1'b0;
            sum_r   <= '0;
            os_r    <= '0;
            oc_r    <= 1'b0;
            ack_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ack_r   <= (state_nxt_s == DONE);
            busy_r  <= (state_nxt_s == RUN) || (state_nxt_s == DONE);
            if (capture_s) begin
                a_r   <= bus.a;
                b_r   <= bus.b;
                c_r   <= bus.ci;
                cnt_r <= '0;
            end else if (step_s) begin
                a_r   <= a_r >> STEP;
                b_r   <= b_r >> STEP;
                c_r   <= co_s;
                sum_r <= sum_nxt_s;
                cnt_r <= cnt_r + CW'(1);
            end
            if (last_s) begin
                os_r <= sum_nxt_s;
                oc_r <= co_s;
            end
        end
    end

    assign bus.ack  = ack_r;
    assign bus.busy = busy_r;

`ifdef A_SUM_NULL_EN
    logic null_r;

    // Remember whether the captured operands contained unknown bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            null_r <= 1'b0;
        end else if (capture_s) begin
            null_r <= $isunknown({bus.a, bus.b, bus.ci});
        end
    end

    assign bus.os = (ack_r && !null_r) ? os_r : {WIDTH{NULL_BIT}};
    assign bus.oc = (ack_r && !null_r) ? oc_r : NULL_BIT;
`else
    assign bus.os = os_r;
    assign bus.oc = oc_r;
`endif
endmodule

// File: tb/tb_a_sum_ser.sv
// Self-checking bench for a_sum_ser: three instances (STEP = 1, 4, 8 at
// WIDTH = 8) driven with the same operands, table-driven vectors plus
// hand-written sequences for mid-RUN changes, req drop and reset.
module tb_a_sum_ser;
    logic       clk = 1'b0;
    logic       rst_t;
    logic       req_t;
    logic [7:0] a_t, b_t;
    logic       ci_t;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    a_sum_ser_if #(.WIDTH(8)) if1 ();
    a_sum_ser_if #(.WIDTH(8)) if4 ();
    a_sum_ser_if #(.WIDTH(8)) if8 ();

    assign if1.req = req_t; assign if1.a = a_t; assign if1.b = b_t; assign if1.ci = ci_t;
    assign if4.req = req_t; assign if4.a = a_t; assign if4.b = b_t; assign if4.ci = ci_t;
    assign if8.req = req_t; assign if8.a = a_t; assign if8.b = b_t; assign if8.ci = ci_t;

    a_sum_ser #(.WIDTH(8), .STEP(1)) dut1 (.clk(clk), .rst(rst_t), .bus(if1.slave));
    a_sum_ser #(.WIDTH(8), .STEP(4)) dut4 (.clk(clk), .rst(rst_t), .bus(if4.slave));
    a_sum_ser #(.WIDTH(8), .STEP(8)) dut8 (.clk(clk), .rst(rst_t), .bus(if8.slave));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] os;
        logic       oc;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Value seen on {oc,os} while ack is low.
    function automatic logic [8:0] idle_exp(input logic [8:0] held);
`ifdef A_SUM_NULL_EN
        return {9{1'bz}};
`else
        return held;
`endif
    endfunction

    // One full transaction with req held until every instance acknowledges.
    task automatic run_vec(input vec_t v, input int idx);
        int lat1, lat4, lat8;
        logic [8:0] exp;
        exp  = {v.oc, v.os};
        lat1 = 0; lat4 = 0; lat8 = 0;
        a_t = v.a; b_t = v.b; ci_t = v.ci; req_t = 1'b1;
        tick();  // capture edge
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) chk($sformatf("v%0d busy_run1", idx), {30'd0, if1.ack, if1.busy}, 32'd1);
            if (lat1 == 0 && if1.ack === 1'b1) lat1 = k;
            if (lat4 == 0 && if4.ack === 1'b1) lat4 = k;
            if (lat8 == 0 && if8.ack === 1'b1) lat8 = k;
            if (lat1 != 0 && lat4 != 0 && lat8 != 0) break;
        end
        chk($sformatf("v%0d lat1", idx), lat1, 32'd8);
        chk($sformatf("v%0d lat4", idx), lat4, 32'd2);
        chk($sformatf("v%0d lat8", idx), lat8, 32'd1);
        chk($sformatf("v%0d res1", idx), {23'd0, if1.oc, if1.os}, {23'd0, exp});
        chk($sformatf("v%0d res4", idx), {23'd0, if4.oc, if4.os}, {23'd0, exp});
        chk($sformatf("v%0d res8", idx), {23'd0, if8.oc, if8.os}, {23'd0, exp});
        req_t = 1'b0;
        a_t = 8'h00; b_t = 8'h00; ci_t = 1'b0;
        tick();
        chk($sformatf("v%0d rel1", idx), {30'd0, if1.ack, if1.busy}, 32'd0);
        chk($sformatf("v%0d rel4", idx), {30'd0, if4.ack, if4.busy}, 32'd0);
        chk($sformatf("v%0d rel8", idx), {30'd0, if8.ack, if8.busy}, 32'd0);
        chk($sformatf("v%0d hold1", idx), {23'd0, if1.oc, if1.os}, {23'd0, idle_exp(exp)});
        chk($sformatf("v%0d hold4", idx), {23'd0, if4.oc, if4.os}, {23'd0, idle_exp(exp)});
        chk($sformatf("v%0d hold8", idx), {23'd0, if8.oc, if8.os}, {23'd0, idle_exp(exp)});
        tick();
    endtask

    vec_t vecs [7];
    logic [11:0] hist;
    logic [8:0]  res;

    initial begin
        vecs[0] = '{a: 8'h5A, b: 8'h3C, ci: 1'b0, os: 8'h96, oc: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'hFF, ci: 1'b1, os: 8'hFF, oc: 1'b1};
        vecs[2] = '{a: 8'hFF, b: 8'h00, ci: 1'b1, os: 8'h00, oc: 1'b1};
        vecs[3] = '{a: 8'h80, b: 8'h80, ci: 1'b0, os: 8'h00, oc: 1'b1};
        vecs[4] = '{a: 8'h00, b: 8'h00, ci: 1'b0, os: 8'h00, oc: 1'b0};
        vecs[5] = '{a: 8'h0F, b: 8'h01, ci: 1'b1, os: 8'h11, oc: 1'b0};
        vecs[6] = '{a: 8'hA5, b: 8'h5A, ci: 1'b1, os: 8'h00, oc: 1'b1};

        // Reset state, with a request pending to show reset wins.
        rst_t = 1'b1; req_t = 1'b1; a_t = 8'h33; b_t = 8'h44; ci_t = 1'b1;
        tick();
        tick();
        chk("rst hs1", {30'd0, if1.ack, if1.busy}, 32'd0);
        chk("rst hs4", {30'd0, if4.ack, if4.busy}, 32'd0);
        chk("rst hs8", {30'd0, if8.ack, if8.busy}, 32'd0);
        chk("rst res1", {23'd0, if1.oc, if1.os}, {23'd0, idle_exp(9'h000)});
        chk("rst res8", {23'd0, if8.oc, if8.os}, {23'd0, idle_exp(9'h000)});
        req_t = 1'b0; rst_t = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
        end

        // Operands change every cycle after capture; req drops mid-RUN.
        a_t = 8'h12; b_t = 8'h34; ci_t = 1'b1; req_t = 1'b1;
        tick();  // capture edge
        hist = 12'h000;
        res  = 9'h000;
        for (int k = 1; k <= 12; k++) begin
            a_t  = a_t + 8'h11;
            b_t  = b_t + 8'h23;
            ci_t = ~ci_t;
            if (k == 3) req_t = 1'b0;
            tick();
            hist[k-1] = if1.ack;
            if (k == 8) res = {if1.oc, if1.os};
        end
        chk("midrun ack_hist", {20'd0, hist}, 32'h080);
        chk("midrun res", {23'd0, res}, 32'h047);
        chk("midrun idle hs", {30'd0, if1.ack, if1.busy}, 32'd0);
        chk("midrun hold", {23'd0, if1.oc, if1.os}, {23'd0, idle_exp(9'h047)});

        // Reset during step 3 of RUN aborts the operation.
        a_t = 8'h77; b_t = 8'h11; ci_t = 1'b0; req_t = 1'b1;
        tick();  // capture edge
        tick();
        tick();
        tick();
        chk("pre-rst busy", {30'd0, if1.ack, if1.busy}, 32'd1);
        rst_t = 1'b1; req_t = 1'b0;
        tick();
        rst_t = 1'b0;
        chk("midrst hs1", {30'd0, if1.ack, if1.busy}, 32'd0);
        chk("midrst res1", {23'd0, if1.oc, if1.os}, {23'd0, idle_exp(9'h000)});
        chk("midrst res4", {23'd0, if4.oc, if4.os}, {23'd0, idle_exp(9'h000)});
        tick();
        run_vec('{a: 8'h01, b: 8'h02, ci: 1'b0, os: 8'h03, oc: 1'b0}, 7);

`ifdef A_SUM_NULL_EN
        // Unknown operand bits at capture give a NULL result with ack high.
        a_t = 8'b0000_zzzz; b_t = 8'h01; ci_t = 1'b0; req_t = 1'b1;
        tick();
        for (int k = 1; k <= 8; k++) tick();
        chk("null ack1", {31'd0, if1.ack}, 32'd1);
        chk("null res1", {23'd0, if1.oc, if1.os}, {23'd0, 9'bz_zzzz_zzzz});
        req_t = 1'b0; a_t = 8'h00;
        tick();
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
